// File: rtl/rv_scoreboard_if.sv
// Issue/writeback handshake bundle between the decode stage and rv_scoreboard.
// master: decode side (drives issue, flush and writeback, reads the verdict).
// slave : scoreboard side.
//   issue_valid/rs1/rs2/use_rs1/use_rs2/rd/wr/lat : instruction presented at decode
//   flush                                        : cancel the previous fire, block issue
//   wb_valid/wb_rd                               : unknown-latency writeback
//   issue_ready/stall                            : hazard verdict
//   fwd_sel_rs1/fwd_sel_rs2                      : 0 = regfile, k+1 = bypass slot k
//   busy_cnt                                     : number of tracked registers in flight
interface rv_scoreboard_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned LAT_W = 3,
  parameter int unsigned SW    = 2
);
  logic             issue_valid;
  logic [AW-1:0]    issue_rs1;
  logic [AW-1:0]    issue_rs2;
  logic             issue_use_rs1;
  logic             issue_use_rs2;
  logic [AW-1:0]    issue_rd;
  logic             issue_wr;
  logic [LAT_W-1:0] issue_lat;
  logic             flush;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic             issue_ready;
  logic             stall;
  logic [SW-1:0]    fwd_sel_rs1;
  logic [SW-1:0]    fwd_sel_rs2;
  logic [AW:0]      busy_cnt;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_wr, issue_lat, flush, wb_valid, wb_rd,
    input  issue_ready, stall, fwd_sel_rs1, fwd_sel_rs2, busy_cnt
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rd, issue_wr, issue_lat, flush, wb_valid, wb_rd,
    output issue_ready, stall, fwd_sel_rs1, fwd_sel_rs2, busy_cnt
  );
endinterface

// File: rtl/rv_scoreboard.sv
// Register scoreboard beside decode: tracks every in-flight destination register
// (fixed or unknown latency) and derives issue stall, per-source bypass selects
// and flush cancellation of the previous issue.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset, clears all tracking
//   sb    : rv_scoreboard_if slave modport (issue, flush, writeback, verdict)
// All outputs are combinational from tracked state plus the current inputs.
module rv_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned LAT_W   = 3,
  parameter int unsigned NUM_BYP = 2,
  parameter int unsigned SW      = 2
) (
  input  logic            clk,
  input  logic            reset,
  rv_scoreboard_if.slave  sb
);

  localparam int unsigned CW = AW + 1;

  // Per-register tracking state; cnt is the WAIT countdown or the BYP slot index.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_UNK  = 2'd2,
    ST_BYP  = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e            kind;
    logic [LAT_W-1:0] cnt;
  } entry_t;

  entry_t        ent_q [NREG];
  entry_t        ent_d [NREG];
  logic          last_valid_q, last_valid_d;
  logic [AW-1:0] last_rd_q, last_rd_d;

  logic raw_rs1, raw_rs2, waw, ready, fire_wr;
  logic [CW-1:0] busy;

  function automatic logic is_pending(entry_t e);
    return (e.kind == ST_WAIT) || (e.kind == ST_UNK);
  endfunction

  function automatic logic [SW-1:0] sel_of(logic hit, entry_t e);
    if (hit && (e.kind == ST_BYP)) return SW'(e.cnt) + SW'(1);
    return '0;
  endfunction

  // Hazard detection and issue verdict.
  always_comb begin
    raw_rs1 = sb.issue_use_rs1 && (sb.issue_rs1 != '0) && is_pending(ent_q[sb.issue_rs1]);
    raw_rs2 = sb.issue_use_rs2 && (sb.issue_rs2 != '0) && is_pending(ent_q[sb.issue_rs2]);
    // Any tracked state on rd blocks a new writer, so entries are never overwritten.
    waw     = sb.issue_wr && (sb.issue_rd != '0) && (ent_q[sb.issue_rd].kind != ST_IDLE);
    ready   = !sb.flush && !raw_rs1 && !raw_rs2 && !waw;
    fire_wr = sb.issue_valid && ready && sb.issue_wr && (sb.issue_rd != '0);
  end

  // Popcount of in-flight registers.
  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      if (ent_q[r].kind != ST_IDLE) busy = busy + CW'(1);
    end
  end

  assign sb.issue_ready = ready;
  assign sb.stall       = sb.issue_valid && !ready;
  assign sb.busy_cnt    = busy;
  assign sb.fwd_sel_rs1 = sel_of(sb.issue_use_rs1 && (sb.issue_rs1 != '0), ent_q[sb.issue_rs1]);
  assign sb.fwd_sel_rs2 = sel_of(sb.issue_use_rs2 && (sb.issue_rs2 != '0), ent_q[sb.issue_rs2]);

  // Next-state: progression, then new issue, then flush cancellation (highest priority).
  always_comb begin
    last_valid_d = fire_wr;
    last_rd_d    = sb.issue_rd;
    for (int r = 0; r < NREG; r++) begin
      ent_d[r] = ent_q[r];
      unique case (ent_q[r].kind)
        ST_WAIT: begin
          if (ent_q[r].cnt == LAT_W'(1)) ent_d[r] = '{kind: ST_BYP, cnt: '0};
          else                           ent_d[r].cnt = ent_q[r].cnt - LAT_W'(1);
        end
        ST_BYP: begin
          if (ent_q[r].cnt == LAT_W'(NUM_BYP - 1)) ent_d[r] = '{kind: ST_IDLE, cnt: '0};
          else                                     ent_d[r].cnt = ent_q[r].cnt + LAT_W'(1);
        end
        ST_UNK: begin
          if (sb.wb_valid && (sb.wb_rd == AW'(r))) ent_d[r] = '{kind: ST_IDLE, cnt: '0};
        end
        default: ;
      endcase
      if (fire_wr && (sb.issue_rd == AW'(r))) begin
        if (sb.issue_lat == '0)             ent_d[r] = '{kind: ST_UNK,  cnt: '0};
        else if (sb.issue_lat == LAT_W'(1)) ent_d[r] = '{kind: ST_BYP,  cnt: '0};
        else                                ent_d[r] = '{kind: ST_WAIT, cnt: sb.issue_lat - LAT_W'(1)};
      end
      if (sb.flush && last_valid_q && (last_rd_q == AW'(r))) ent_d[r] = '{kind: ST_IDLE, cnt: '0};
    end
    ent_d[0] = '{kind: ST_IDLE, cnt: '0};
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) ent_q[r] <= '{kind: ST_IDLE, cnt: '0};
      last_valid_q <= 1'b0;
      last_rd_q    <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) ent_q[r] <= ent_d[r];
      last_valid_q <= last_valid_d;
      last_rd_q    <= last_rd_d;
    end
  end

endmodule

// File: tb/tb_rv_scoreboard.sv
// Self-checking bench for rv_scoreboard: directed scenarios followed by random
// traffic, compared every cycle against a timestamp-based reference model.
module tb_rv_scoreboard;

  localparam int NREG    = 32;
  localparam int NUM_BYP = 2;
  localparam int IDLE_T  = -1000;

  logic clk;
  logic reset;

  rv_scoreboard_if #(.AW(5), .LAT_W(3), .SW(2)) sb_if ();

  rv_scoreboard #(.NREG(32), .AW(5), .LAT_W(3), .NUM_BYP(2), .SW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a fixed-latency result is usable from cycle m_ready[r];
  // unknown-latency results are pending while m_unk[r] is set.
  int now;
  int m_ready [NREG];
  bit m_unk   [NREG];
  bit m_last_v;
  int m_last_rd;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_block(int r);
    if (r == 0) return 1'b0;
    return m_unk[r] || (now - m_ready[r] < 0);
  endfunction

  function automatic bit m_busy(int r);
    if (r == 0) return 1'b0;
    return m_unk[r] || (now - m_ready[r] < NUM_BYP);
  endfunction

  function automatic int m_fwd(int r);
    int d;
    if (r == 0 || m_unk[r]) return 0;
    d = now - m_ready[r];
    if (d >= 0 && d < NUM_BYP) return d + 1;
    return 0;
  endfunction

  function automatic bit m_issue_ready();
    bit raw1, raw2, waw;
    raw1 = sb_if.issue_use_rs1 && m_block(int'(sb_if.issue_rs1));
    raw2 = sb_if.issue_use_rs2 && m_block(int'(sb_if.issue_rs2));
    waw  = sb_if.issue_wr && m_busy(int'(sb_if.issue_rd));
    return !sb_if.flush && !raw1 && !raw2 && !waw;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_ready[r] = IDLE_T;
      m_unk[r]   = 1'b0;
    end
    m_last_v  = 1'b0;
    m_last_rd = 0;
    now       = 0;
  endtask

  task automatic drive(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr,
                       int lat, bit fl, bit wbv, int wbrd);
    sb_if.issue_valid   = v;
    sb_if.issue_rs1     = 5'(rs1);
    sb_if.issue_use_rs1 = u1;
    sb_if.issue_rs2     = 5'(rs2);
    sb_if.issue_use_rs2 = u2;
    sb_if.issue_rd      = 5'(rd);
    sb_if.issue_wr      = wr;
    sb_if.issue_lat     = 3'(lat);
    sb_if.flush         = fl;
    sb_if.wb_valid      = wbv;
    sb_if.wb_rd         = 5'(wbrd);
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called just after inputs change at a falling edge; checks, clocks, updates model.
  task automatic step(output bit fired);
    bit er;
    int busy, rd;
    #1;
    er   = m_issue_ready();
    busy = 0;
    for (int r = 1; r < NREG; r++) busy += int'(m_busy(r));
    check_eq("issue_ready", 32'(sb_if.issue_ready), 32'(er));
    check_eq("stall", 32'(sb_if.stall), 32'(sb_if.issue_valid && !er));
    check_eq("fwd_sel_rs1", 32'(sb_if.fwd_sel_rs1),
             sb_if.issue_use_rs1 ? 32'(m_fwd(int'(sb_if.issue_rs1))) : 32'd0);
    check_eq("fwd_sel_rs2", 32'(sb_if.fwd_sel_rs2),
             sb_if.issue_use_rs2 ? 32'(m_fwd(int'(sb_if.issue_rs2))) : 32'd0);
    check_eq("busy_cnt", 32'(sb_if.busy_cnt), 32'(busy));
    fired = sb_if.issue_valid && er;
    @(posedge clk);
    rd = int'(sb_if.issue_rd);
    if (sb_if.wb_valid) m_unk[int'(sb_if.wb_rd)] = 1'b0;
    if (fired && sb_if.issue_wr && rd != 0) begin
      if (sb_if.issue_lat == 3'd0) m_unk[rd] = 1'b1;
      else                         m_ready[rd] = now + int'(sb_if.issue_lat);
    end
    if (sb_if.flush && m_last_v) begin
      m_unk[m_last_rd]   = 1'b0;
      m_ready[m_last_rd] = IDLE_T;
    end
    m_last_v  = fired && sb_if.issue_wr && rd != 0;
    m_last_rd = rd;
    now++;
    @(negedge clk);
  endtask

  // Hold the currently driven instruction until it fires; returns stall count.
  task automatic run_until_fire(string tag, int max_cyc, output int stalls);
    bit f;
    stalls = 0;
    for (int i = 0; i < max_cyc; i++) begin
      step(f);
      if (f) return;
      stalls++;
    end
    check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    drive(1, 5, 1, 9, 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_eq("rst_busy_cnt", 32'(sb_if.busy_cnt), 32'd0);
    check_eq("rst_issue_ready", 32'(sb_if.issue_ready), 32'd1);
    check_eq("rst_stall", 32'(sb_if.stall), 32'd0);
    check_eq("rst_fwd_sel_rs1", 32'(sb_if.fwd_sel_rs1), 32'd0);
    check_eq("rst_fwd_sel_rs2", 32'(sb_if.fwd_sel_rs2), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_checks);
    $fatal(1);
  end

  initial begin
    bit f;
    int st;
    reset = 1'b1;
    drive_idle();
    model_clear();
    @(negedge clk);
    do_reset();

    // Idle cycle after reset.
    step(f);

    // ALU result forwarded through both bypass slots then retired.
    drive(1, 1, 0, 2, 0, 5, 1, 1, 0, 0, 0);      // add x5
    step(f);
    check_eq("alu_fire", 32'(f), 32'd1);
    drive(1, 5, 1, 5, 1, 6, 1, 1, 0, 0, 0);      // sub x6,x5,x5
    #1;
    check_eq("alu_slot0_rs1", 32'(sb_if.fwd_sel_rs1), 32'd1);
    check_eq("alu_slot0_rs2", 32'(sb_if.fwd_sel_rs2), 32'd1);
    step(f);
    check_eq("alu_reader_fire", 32'(f), 32'd1);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("alu_slot1_rs1", 32'(sb_if.fwd_sel_rs1), 32'd2);
    step(f);
    step(f);
    check_eq("alu_retired_rs1", 32'(sb_if.fwd_sel_rs1), 32'd0);

    // Load: one stall cycle then slot 0.
    drive(1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0);      // lw x7
    step(f);
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_until_fire("load_use", 10, st);
    check_eq("load_stalls", 32'(st), 32'd1);

    // Divide: unknown latency, writeback arrives while the reader waits.
    drive_idle();
    step(f);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);      // div x9
    step(f);
    st = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0, (i == 5), 9);
      step(f);
      if (f) break;
      st++;
    end
    check_eq("div_stalls", 32'(st), 32'd6);

    // Flush cancels the previous issue.
    drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);      // add x3
    step(f);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    check_eq("flush_ready", 32'(sb_if.issue_ready), 32'd0);
    step(f);
    drive(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    #1;
    check_eq("flush_busy", 32'(sb_if.busy_cnt), 32'd0);
    check_eq("flush_fwd", 32'(sb_if.fwd_sel_rs1), 32'd0);
    step(f);

    // WAW on x4 stalls until the first write fully retires.
    drive(1, 0, 0, 0, 0, 4, 1, 3, 0, 0, 0);
    step(f);
    drive(1, 0, 1, 0, 1, 4, 1, 1, 0, 0, 0);
    run_until_fire("waw", 20, st);
    check_eq("waw_stalls", 32'(st), 32'd4);

    // x0 destination is never tracked, x0 sources never stall.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(f);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    run_until_fire("x0_src", 5, st);
    check_eq("x0_stalls", 32'(st), 32'd0);

    // Random traffic on a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 1),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 4, $urandom_range(0, 7));
      step(f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_scoreboard.md
# rv_scoreboard

Parametrised register scoreboard for the RV32I pipeline, one generation beyond the fixed 5-stage hazard and forwarding units. It sits beside the decode stage and tracks every in-flight destination register. The tracked results may have fixed latency (ALU, load, multicycle) or unknown latency (writeback-completed, e.g. divide). From that state it produces the issue stall, per-source bypass-slot selects and flush cancellation for a configurable number of bypass stages.

## Interface
- NREG, 32: architectural registers; x0 is hardwired zero and never tracked.
- AW, 5: register address width, equal to clog2(NREG).
- LAT_W, 3: width of issue latency field.
- NUM_BYP, 2: bypass slots after result-ready; slot 0 = EX/MEM, slot 1 = MEM/WB, etc.
- SW, 2: select width, enough for NUM_BYP+1 codes.
- clk  in  1  clock; one clock.
- reset  in  1  asynchronous, active-high reset.
- issue_valid  in  1  decode stage holds an instruction.
- issue_rs1, issue_rs2  in  AW  source registers.
- issue_use_rs1, issue_use_rs2  in  1  source is actually read.
- issue_rd  in  AW  destination register.
- issue_wr  in  1  instruction writes rd.
- issue_lat  in  LAT_W  cycles to result-ready; 0 = unknown latency.
- flush  in  1  cancel the instruction issued at the previous edge and block current issue.
- wb_valid  in  1  unknown-latency result written back this cycle.
- wb_rd  in  AW  register of that writeback.
- issue_ready  out  1  no hazard; fire = issue_valid & issue_ready.
- stall  out  1  issue_valid & ~issue_ready.
- fwd_sel_rs1, fwd_sel_rs2  out  SW  0 = regfile, k+1 = bypass slot k.
- busy_cnt  out  AW+1  number of tracked registers not IDLE.

## Operation
- Each register r (1..NREG-1) holds one of four states:
  - IDLE.
  - WAIT(cnt), with cnt from 1 to 2^LAT_W-2.
  - UNK.
  - BYP(k), with k from 0 to NUM_BYP-1.
- On fire with issue_wr=1 and rd≠0, the entry for rd becomes:
  - UNK if issue_lat=0.
  - BYP(0) if issue_lat=1.
  - WAIT(issue_lat-1) otherwise.
- Per-edge progression of non-issued entries:
  - WAIT(1) becomes BYP(0).
  - WAIT(c) becomes WAIT(c-1).
  - BYP(k) becomes BYP(k+1).
  - BYP(NUM_BYP-1) becomes IDLE.
  - UNK holds until wb_valid with wb_rd=r, then becomes IDLE.
- wb_valid for a register that is not in UNK is ignored.
- RAW hazard: a used source (rs≠0) whose entry is WAIT or UNK.
- WAW hazard: issue_wr, rd≠0, and the rd entry is not IDLE. Any pending state stalls, so overwrite never occurs.
- issue_ready = ~flush & ~RAW & ~WAW; it is independent of issue_valid.
- fwd_sel: 0 if the source is unused, is x0, or its entry is IDLE/WAIT/UNK; k+1 if its entry is BYP(k).
- Flush: a registered record (last_valid, last_rd) of the previous edge's fire with issue_wr. If flush=1 and last_valid, that entry goes to IDLE at the next edge, overriding progression. last_valid clears every edge without a fire.
- busy_cnt: combinational popcount of non-IDLE entries.

## Timing
- Reset, asynchronous, effective immediately:
  - All entries IDLE; last_valid=0.
  - busy_cnt=0, fwd_sel=0.
  - issue_ready=1 (if flush=0); stall=0.
- All outputs are combinational from registered state plus the current inputs. All state updates occur at the clk rising edge.
- ALU (lat=1) fired at edge t: at cycle t+1 a dependent instruction sees fwd_sel=1, and at t+2 sees fwd_sel=2. With NUM_BYP=2 the entry is IDLE from t+3 and fwd_sel=0.
- Load (lat=2) fired at edge t: a dependent instruction stalls during cycle t+1, then sees fwd_sel=1 at t+2.
- Unknown-latency: readers stall until the cycle after the edge that samples wb_valid. They then get fwd_sel=0, since the regfile is written at that same edge.
- Simultaneous flush and wb_valid on the same rd: the entry goes to IDLE.
- Fire is impossible while flush=1.
- A reset asserted mid-operation discards all in-flight tracking.

## Test plan
- Reset, then an idle cycle: issue_ready=1, busy_cnt=0, both fwd_sel=0.
- Fire add x5 (lat 1), then sub x6,x5,x5: no stall, fwd_sel_rs1=fwd_sel_rs2=1. A further reader of x5 one cycle later gets 2, and three cycles after the fire gets 0.
- Fire lw x7 (lat 2), then a reader of x7: exactly one stall cycle, then fwd_sel=1 and busy_cnt=1.
- Fire div x9 (lat 0), then a reader of x9, with wb_valid/wb_rd=9 asserted 5 cycles later: stall for 6 cycles, fwd_sel=0 afterwards.
- Fire add x3, then flush next cycle: issue_ready=0 that cycle, x3 is IDLE after the edge, busy_cnt=0, and a reader of x3 gets fwd_sel=0.
- Fire lat 3 to x4, then issue another write to x4 (WAW): stall until the x4 entry is IDLE. Also, a source of x0 with a pending state never stalls.
